// File: rtl/logic_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : logic_unit_pkg
//  Purpose  : Op and state encodings shared by the bitwise logic unit.
//  Revision : 1.0  initial release
// ============================================================================
package logic_unit_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/logic_slice.sv
`default_nettype none
// ============================================================================
//  Module   : logic_slice
//  Purpose  : Combinational AND/OR/XOR/pass-B on one SLICE-bit chunk.
//  Revision : 1.0  initial release
// ============================================================================
module logic_slice
    import logic_unit_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] A,
    input  logic [SLICE-1:0] B,
    input  logic [1:0]       OP,
    output logic [SLICE-1:0] Y
);

    always_comb begin
        Y = '0;
        case (OP)
            OP_AND:  Y = A & B;
            OP_OR:   Y = A | B;
            OP_XOR:  Y = A ^ B;
            OP_PASS: Y = B;
            default: Y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bitwise_logic_unit.sv
`default_nettype none
// ============================================================================
//  Module   : bitwise_logic_unit
//  Purpose  : Multi-cycle WIDTH-bit bitwise unit, SLICE bits per cycle, with
//             valid/ready handshakes. Optional ZERO flag: LOGIC_ZERO_FLAG_EN.
//  Revision : 1.0  initial release
// ============================================================================
module bitwise_logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [1:0]       OP,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RESULT
`ifdef LOGIC_ZERO_FLAG_EN
    ,
    output logic             ZERO
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
        $error("bitwise_logic_unit: WIDTH must be >= 1 and a multiple of SLICE");
    end

    state_t                        state;
    state_t                        state_next;
    logic [CNT_W-1:0]              cnt;
    logic [1:0]                    op_q;
    logic [NSLICE-1:0][SLICE-1:0]  d1_q;
    logic [NSLICE-1:0][SLICE-1:0]  d2_q;
    logic [NSLICE-1:0][SLICE-1:0]  result_q;
    logic [NSLICE-1:0][SLICE-1:0]  result_next;
    logic [SLICE-1:0]              slice_y;
    logic                          last_slice;

    assign last_slice = (cnt == CNT_W'(NSLICE - 1));
    assign IN_READY   = (state == IDLE);
    assign OUT_VALID  = (state == DONE);
    assign RESULT     = result_q;

    logic_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .A  (d1_q[cnt]),
        .B  (d2_q[cnt]),
        .OP (op_q),
        .Y  (slice_y)
    );

    always_comb begin
        result_next      = result_q;
        result_next[cnt] = slice_y;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (IN_VALID)   state_next = BUSY;
            BUSY:    if (last_slice) state_next = DONE;
            DONE:    if (OUT_READY)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Operand capture and slice-by-slice result build-up
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt      <= '0;
            op_q     <= OP_AND;
            d1_q     <= '0;
            d2_q     <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        d1_q     <= DATA1;
                        d2_q     <= DATA2;
                        op_q     <= OP;
                        cnt      <= '0;
                        result_q <= '0;
                    end
                end
                BUSY: begin
                    result_q <= result_next;
                    cnt      <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef LOGIC_ZERO_FLAG_EN
    logic zero_q;

    assign ZERO = zero_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            zero_q <= 1'b0;
        end else if (state == IDLE && IN_VALID) begin
            zero_q <= 1'b0;
        end else if (state == BUSY && last_slice) begin
            zero_q <= (result_next == '0);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bitwise_logic_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bitwise_logic_unit
//  Purpose  : Self-checking bench for bitwise_logic_unit (8/4, 32/32, 32/8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_bitwise_logic_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  data1, data2, result;
    logic [1:0]  op;
    logic        in_valid32, out_ready32;
    logic [31:0] d1_32, d2_32, result32a, result32b;
    logic [1:0]  op32;
    logic        in_ready32a, out_valid32a, in_ready32b, out_valid32b;
`ifdef LOGIC_ZERO_FLAG_EN
    logic        zero, zero32a, zero32b;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    bitwise_logic_unit #(.WIDTH(8), .SLICE(4)) u_dut (
        .CLK(clk), .RESET(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .DATA1(data1), .DATA2(data2), .OP(op), .OUT_VALID(out_valid),
        .OUT_READY(out_ready), .RESULT(result)
`ifdef LOGIC_ZERO_FLAG_EN
        , .ZERO(zero)
`endif
    );

    bitwise_logic_unit #(.WIDTH(32), .SLICE(32)) u_dut32a (
        .CLK(clk), .RESET(rst), .IN_VALID(in_valid32), .IN_READY(in_ready32a),
        .DATA1(d1_32), .DATA2(d2_32), .OP(op32), .OUT_VALID(out_valid32a),
        .OUT_READY(out_ready32), .RESULT(result32a)
`ifdef LOGIC_ZERO_FLAG_EN
        , .ZERO(zero32a)
`endif
    );

    bitwise_logic_unit #(.WIDTH(32), .SLICE(8)) u_dut32b (
        .CLK(clk), .RESET(rst), .IN_VALID(in_valid32), .IN_READY(in_ready32b),
        .DATA1(d1_32), .DATA2(d2_32), .OP(op32), .OUT_VALID(out_valid32b),
        .OUT_READY(out_ready32), .RESULT(result32b)
`ifdef LOGIC_ZERO_FLAG_EN
        , .ZERO(zero32b)
`endif
    );

    function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] o);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return b;
        endcase
    endfunction

    // One full 8-bit transaction with OUT_READY high; starts and ends in IDLE.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o,
                          input bit toggle, input string tag);
        logic [7:0] exp;
        int lat;
        exp = 8'(ref_model({24'd0, a}, {24'd0, b}, o));
        data1 = a; data2 = b; op = o; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL %s_in_ready_drop: got %b want 0", tag, in_ready);
        else pass_cnt++;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            if (toggle) begin
                data1 = 8'($urandom); data2 = 8'($urandom); op = 2'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        total_cnt++;
        if (lat != 2) $display("FAIL %s_latency: got %0d want 2", tag, lat);
        else pass_cnt++;
        total_cnt++;
        if (result !== exp) $display("FAIL %s_result: got %h want %h", tag, result, exp);
        else pass_cnt++;
`ifdef LOGIC_ZERO_FLAG_EN
        total_cnt++;
        if (zero !== (exp == 8'h00)) $display("FAIL %s_zero: got %b want %b", tag, zero, exp == 8'h00);
        else pass_cnt++;
`endif
        @(posedge clk); #1;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL %s_to_idle: got ov=%b ir=%b want ov=0 ir=1", tag, out_valid, in_ready);
        else pass_cnt++;
        total_cnt++;
        if (result !== exp) $display("FAIL %s_hold: got %h want %h", tag, result, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 8'h00)
            $display("FAIL reset_state: got ir=%b ov=%b res=%h want ir=1 ov=0 res=00",
                     in_ready, out_valid, result);
        else pass_cnt++;
        total_cnt++;
        if (in_ready32b !== 1'b1 || out_valid32b !== 1'b0 || result32b !== 32'h0)
            $display("FAIL reset_state32: got ir=%b ov=%b res=%h want ir=1 ov=0 res=0",
                     in_ready32b, out_valid32b, result32b);
        else pass_cnt++;
`ifdef LOGIC_ZERO_FLAG_EN
        total_cnt++;
        if (zero !== 1'b0) $display("FAIL reset_zero: got %b want 0", zero);
        else pass_cnt++;
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        run_op(8'hF0, 8'h3C, 2'b00, 1'b0, "and_f0_3c");
        run_op(8'hA5, 8'h0F, 2'b01, 1'b1, "or_a5_0f");
        run_op(8'hA5, 8'h0F, 2'b10, 1'b1, "xor_a5_0f");
        run_op(8'hA5, 8'h0F, 2'b11, 1'b1, "pass_a5_0f");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            run_op(8'($urandom), 8'($urandom), 2'($urandom), 1'b1, "random");
    endtask

    task automatic test_back_pressure();
        int lat;
        out_ready = 1'b0;
        data1 = 8'hC3; data2 = 8'h5A; op = 2'b10; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        total_cnt++;
        if (lat != 2) $display("FAIL bp_latency: got %0d want 2", lat);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; data1 = 8'($urandom); data2 = 8'($urandom); op = 2'($urandom);
            @(posedge clk); #1;
            total_cnt++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 8'h99)
                $display("FAIL bp_hold: got ov=%b ir=%b res=%h want ov=1 ir=0 res=99",
                         out_valid, in_ready, result);
            else pass_cnt++;
        end
        data1 = 8'h6E; data2 = 8'hB7; op = 2'b01; out_ready = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 8'h99)
            $display("FAIL bp_release: got ov=%b ir=%b res=%h want ov=0 ir=1 res=99",
                     out_valid, in_ready, result);
        else pass_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL bp_next_accept: got %b want 0", in_ready);
        else pass_cnt++;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        total_cnt++;
        if (lat != 2 || result !== 8'hFF)
            $display("FAIL bp_next_result: got lat=%0d res=%h want lat=2 res=ff", lat, result);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int seen;
        int lat;
        data1 = 8'hFF; data2 = 8'hFF; op = 2'b00; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total_cnt++;
        if (result !== 8'h00 || out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rst_busy: got res=%h ov=%b ir=%b want res=00 ov=0 ir=1",
                     result, out_valid, in_ready);
        else pass_cnt++;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        total_cnt++;
        if (seen != 0) $display("FAIL rst_busy_no_valid: got %0d valid cycles want 0", seen);
        else pass_cnt++;
        out_ready = 1'b0;
        data1 = 8'hF0; data2 = 8'h0F; op = 2'b01; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        total_cnt++;
        if (result !== 8'hFF) $display("FAIL rst_done_pre: got %h want ff", result);
        else pass_cnt++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total_cnt++;
        if (result !== 8'h00 || out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rst_done: got res=%h ov=%b ir=%b want res=00 ov=0 ir=1",
                     result, out_valid, in_ready);
        else pass_cnt++;
        out_ready = 1'b1;
    endtask

    task automatic run_wide(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                            input string tag);
        logic [31:0] exp;
        int lat_a, lat_b;
        exp = ref_model(a, b, o);
        d1_32 = a; d2_32 = b; op32 = o; in_valid32 = 1'b1; out_ready32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        d1_32 = $urandom; d2_32 = $urandom; op32 = 2'($urandom);
        total_cnt++;
        if (in_ready32a !== 1'b0 || in_ready32b !== 1'b0)
            $display("FAIL %s_accept: got ira=%b irb=%b want 0 0", tag, in_ready32a, in_ready32b);
        else pass_cnt++;
        lat_a = -1; lat_b = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (out_valid32a === 1'b1 && lat_a < 0) begin
                lat_a = c;
                total_cnt++;
                if (result32a !== exp) $display("FAIL %s_res_s32: got %h want %h", tag, result32a, exp);
                else pass_cnt++;
            end
            if (out_valid32b === 1'b1 && lat_b < 0) begin
                lat_b = c;
                total_cnt++;
                if (result32b !== exp) $display("FAIL %s_res_s8: got %h want %h", tag, result32b, exp);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (lat_a != 1 || lat_b != 4)
            $display("FAIL %s_latency: got s32=%0d s8=%0d want s32=1 s8=4", tag, lat_a, lat_b);
        else pass_cnt++;
    endtask

    task automatic test_wide();
        run_wide(32'hDEADBEEF, 32'hFFFF0000, 2'b00, "wide_dead");
        for (int i = 0; i < 4; i++)
            run_wide($urandom, $urandom, 2'($urandom), "wide_rand");
    endtask

`ifdef LOGIC_ZERO_FLAG_EN
    task automatic test_zero();
        run_op(8'h0F, 8'hF0, 2'b00, 1'b0, "zero_set");
        run_op(8'h01, 8'h01, 2'b00, 1'b0, "zero_clr");
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        data1 = '0; data2 = '0; op = '0;
        in_valid32 = 1'b0; out_ready32 = 1'b1; d1_32 = '0; d2_32 = '0; op32 = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_pressure();
        test_reset_mid();
        test_wide();
`ifdef LOGIC_ZERO_FLAG_EN
        test_zero();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bitwise_logic_unit.md
Name: bitwise_logic_unit

Overview:
- Parametrised, multi-cycle successor to the fixed 8-bit AND stage in the processor ALU.
- Performs AND, OR, XOR or pass-through on WIDTH-bit operands, SLICE bits per cycle.
- Uses a valid/ready handshake on both sides, so the ALU control stalls on it rather than relying on a fixed gate delay.
- Sits beside the adder in the ALU datapath; the result feeds the register-file write-back mux.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥1.
- SLICE, 4, bits processed per cycle; WIDTH must be an integer multiple of SLICE (elaboration error otherwise).

Ports:
- CLK  input  1  clock, rising-edge.
- RESET  input  1  synchronous reset, active-high.
- IN_VALID  input  1  operands/op presented.
- IN_READY  output  1  unit can accept; high only in IDLE.
- DATA1  input  WIDTH  operand 1.
- DATA2  input  WIDTH  operand 2.
- OP  input  2  00 AND, 01 OR, 10 XOR, 11 pass DATA2.
- OUT_VALID  output  1  RESULT valid; high only in DONE.
- OUT_READY  input  1  consumer accepts RESULT.
- RESULT  output  WIDTH  registered result.

Behaviour:
- One clock (CLK); RESET is synchronous and active-high, sampled on rising CLK.
- NSLICE = WIDTH/SLICE.
- States: IDLE, BUSY, DONE.
- Reset values:
  - state = IDLE; slice counter = 0.
  - RESULT = 0; OUT_VALID = 0.
  - Operand/op capture registers = 0.
  - IN_READY = 1 from the first cycle after reset (decoded from state).
- IDLE:
  - IN_READY = 1.
  - On IN_VALID && IN_READY at a rising edge: capture DATA1, DATA2, OP; clear counter; clear RESULT to 0; go to BUSY.
- BUSY:
  - Each cycle, compute slice [cnt*SLICE +: SLICE] from the captured operands and write it into RESULT; cnt++.
  - The write at cnt == NSLICE-1 moves the state to DONE.
  - Inputs are ignored in this state; changes to DATA1, DATA2 and OP after capture have no effect.
- DONE:
  - OUT_VALID = 1; RESULT is stable.
  - On OUT_READY, go to IDLE at the next edge. OUT_VALID falls and RESULT holds its value until the next capture.
- Latency:
  - Acceptance at edge E0; OUT_VALID is high after edge E0+NSLICE.
  - If SLICE == WIDTH, OUT_VALID rises 1 cycle after acceptance.
- Throughput: at most one operation per NSLICE+2 cycles. There is no acceptance in DONE, even if OUT_READY is high.
- Back-pressure: OUT_READY low holds DONE indefinitely, with OUT_VALID and RESULT constant.
- RESET mid-operation (BUSY or DONE): abandon the operation; all registers return to their reset values next edge; no OUT_VALID for the abandoned operation.
- RESET has priority over simultaneous IN_VALID or OUT_READY.
- Width rule: pure bitwise, no carry between slices. The partial RESULT during BUSY is undefined for consumers; only the value under OUT_VALID is meaningful.

Optional Feature:
- Macro: LOGIC_ZERO_FLAG_EN.
- Defined:
  - Adds output port ZERO (1 bit), registered.
  - Reset value 0; cleared at capture.
  - Set on the BUSY→DONE transition to 1 iff the final RESULT == 0; valid while OUT_VALID.
  - Used by the branch-on-zero logic.
- Undefined: ZERO port and its logic are absent; the other behaviour is identical.

Decomposition:
- Package logic_unit_pkg:
  - Op encoding constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_PASS=2'b11.
  - State encoding IDLE/BUSY/DONE.
- Sub-module logic_slice: combinational, parameter SLICE; inputs A, B [SLICE], OP; output Y [SLICE]. One instance, fed by the slice mux.

Test Plan:
- WIDTH=8, SLICE=4, DATA1=8'hF0, DATA2=8'h3C, OP=AND, OUT_READY=1: IN_READY drops; OUT_VALID after 2 cycles with RESULT=8'h30; IDLE 1 cycle later.
- Same config, OR / XOR / PASS on 8'hA5, 8'h0F: RESULT=8'hAF, 8'hAA, 8'h0F. Operands toggled during BUSY do not change the results.
- OUT_READY held low 5 cycles in DONE: OUT_VALID and RESULT stay constant; a new IN_VALID is not accepted until after the handshake.
- RESET asserted in the 1st BUSY cycle: next edge has RESULT=0, OUT_VALID=0, IN_READY=1; no OUT_VALID is ever produced for that operation.
- WIDTH=32, SLICE=32, DATA1=32'hDEADBEEF, DATA2=32'hFFFF0000, AND: OUT_VALID 1 cycle after acceptance, RESULT=32'hDEAD0000. Repeat with WIDTH=32, SLICE=8: OUT_VALID after 4 cycles, same result.
- With LOGIC_ZERO_FLAG_EN defined, 8'h0F AND 8'hF0: RESULT=0, ZERO=1. A following 8'h01 AND 8'h01: ZERO=0.
